// File: rtl/gb_pkg.sv
// Shared SM83 system definitions: DMA state encoding and the memory-map constants
// used by the top-level decoder and bus mux.
package gb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int          OAM_LEN      = 160;

endpackage

// File: rtl/oam_dma_if.sv
// OAM DMA bus bundle: CPU register access, source-memory read port and OAM write port.
// master = DMA controller side, slave = system (decoder, memories, CPU) side.
interface oam_dma_if;
    logic        reg_write;
    logic [7:0]  reg_in;
    logic [7:0]  reg_out;
    logic        busy;
    logic        dma_active;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_write;

    modport master (
        input  reg_write, reg_in, src_data,
        output reg_out, busy, dma_active, src_addr, src_rd, oam_addr, oam_data, oam_write
    );

    modport slave (
        output reg_write, reg_in, src_data,
        input  reg_out, busy, dma_active, src_addr, src_rd, oam_addr, oam_data, oam_write
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA controller: copies LEN bytes from page {page,00} into OAM, one byte per cycle.
// Latency: first OAM write START_DELAY cycles after the register strobe; no backpressure.
// Optional OAM_DMA_ECHO_FOLD_EN folds source pages E0-FF down by 0x20.
module oam_dma
    import gb_pkg::*;
#(
    parameter int LEN         = OAM_LEN,
    parameter int START_DELAY = 1
) (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_DELAY = 2'(DELAY);
    localparam logic [1:0] ST_XFER  = 2'(XFER);

    localparam int              DW        = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DW-1:0]   DCNT_LAST = DW'(START_DELAY - 1);
    localparam logic [7:0]      IDX_LAST  = 8'(LEN - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    page_q, page_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [7:0]    idx_q, idx_d;
    logic [15:0]   src_hold_q, src_hold_d;
    logic [7:0]    oam_hold_q, oam_hold_d;

    logic          xfer;
    logic [7:0]    page_eff;
    logic [15:0]   cur_src;

`ifdef OAM_DMA_ECHO_FOLD_EN
    // Echo RAM aliases WRAM; folding keeps DMA away from OAM and I/O space.
    assign page_eff = (page_q[7:5] == 3'b111) ? {page_q[7:6], 1'b0, page_q[4:0]} : page_q;
`else
    assign page_eff = page_q;
`endif

    assign xfer    = (state_q == ST_XFER);
    assign cur_src = {page_eff, idx_q};

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        dcnt_d     = dcnt_q;
        idx_d      = idx_q;
        src_hold_d = src_hold_q;
        oam_hold_d = oam_hold_q;

        if (xfer) begin
            src_hold_d = cur_src;
            oam_hold_d = idx_q;
        end

        // A register write restarts from any state, including the final XFER cycle.
        if (bus.reg_write) begin
            page_d  = bus.reg_in;
            dcnt_d  = '0;
            idx_d   = '0;
            state_d = ST_DELAY;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DELAY: begin
                    if (dcnt_q == DCNT_LAST) begin
                        state_d = ST_XFER;
                        idx_d   = '0;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                ST_XFER: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            page_q     <= 8'h00;
            dcnt_q     <= '0;
            idx_q      <= 8'h00;
            src_hold_q <= 16'h0000;
            oam_hold_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            dcnt_q     <= dcnt_d;
            idx_q      <= idx_d;
            src_hold_q <= src_hold_d;
            oam_hold_q <= oam_hold_d;
        end
    end

    // Strobes come from registered state only; src_data -> oam_data is the one combinational path.
    assign bus.reg_out    = page_q;
    assign bus.busy       = (state_q == ST_DELAY) || xfer;
    assign bus.dma_active = xfer;
    assign bus.src_rd     = xfer;
    assign bus.oam_write  = xfer;
    assign bus.src_addr   = xfer ? cur_src : src_hold_q;
    assign bus.oam_addr   = xfer ? idx_q : oam_hold_q;
    assign bus.oam_data   = xfer ? bus.src_data : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: a default instance (LEN=160, START_DELAY=1) and a
// short instance (LEN=8, START_DELAY=4); expected OAM writes are queued per transfer.
module tb_oam_dma;

    typedef struct packed {
        logic [15:0] src;
        logic [7:0]  oa;
        logic [7:0]  dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    oam_dma_if ifa();
    oam_dma_if ifb();

    oam_dma dut_a (.clk(clk), .rst(rst), .bus(ifa));
    oam_dma #(.LEN(8), .START_DELAY(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] eff(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_FOLD_EN
        return (p >= 8'hE0) ? p - 8'h20 : p;
`else
        return p;
`endif
    endfunction

    assign ifa.src_data = pat(ifa.src_addr);
    assign ifb.src_data = pat(ifb.src_addr);

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit to_b, input logic [7:0] pg, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.src = {eff(pg), 8'(i)};
            e.oa  = 8'(i);
            e.dat = pat(e.src);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    // Caller sits just after a rising edge; the strobe is sampled at the next edge (T).
    // left >= 0 checks how many old expectations were still outstanding at T.
    task automatic wr_a(input logic [7:0] pg, input int left);
        ifa.reg_write = 1'b1;
        ifa.reg_in    = pg;
        @(posedge clk);
        #1;
        ifa.reg_write = 1'b0;
        if (left >= 0) chk("a_pending_at_strobe", 16'(qa.size()), 16'(left));
        qa.delete();
        push(1'b0, pg, 160);
        chk("a_reg_out", 16'(ifa.reg_out), 16'(pg));
        chk("a_busy_rise", 16'(ifa.busy), 16'd1);
        chk("a_delay_not_active", 16'(ifa.dma_active), 16'd0);
    endtask

    // After wr_a returns (T+1ns), run to completion and check busy timing and hold values.
    task automatic finish_a(input logic [7:0] pg);
        repeat (160) @(posedge clk);
        #1;
        chk("a_busy_last_cycle", 16'(ifa.busy), 16'd1);
        @(posedge clk);
        #1;
        chk("a_busy_fall", 16'(ifa.busy), 16'd0);
        chk("a_all_written", 16'(qa.size()), 16'd0);
        chk("a_src_hold", ifa.src_addr, {eff(pg), 8'h9F});
        chk("a_oam_hold", 16'(ifa.oam_addr), 16'h009F);
        chk("a_idle_data", 16'(ifa.oam_data), 16'h0000);
        chk("a_idle_rd", 16'(ifa.src_rd), 16'd0);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_busy", 16'(ifa.busy), 16'd0);
        chk("rst_active", 16'(ifa.dma_active), 16'd0);
        chk("rst_src_addr", ifa.src_addr, 16'h0000);
        chk("rst_src_rd", 16'(ifa.src_rd), 16'd0);
        chk("rst_oam_addr", 16'(ifa.oam_addr), 16'h0000);
        chk("rst_oam_data", 16'(ifa.oam_data), 16'h0000);
        chk("rst_oam_write", 16'(ifa.oam_write), 16'd0);
        chk("rst_reg_out", 16'(ifa.reg_out), 16'h0000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifa.oam_write) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_write", 16'(ifa.oam_addr), 16'hFFFF);
            end else begin
                e = qa.pop_front();
                chk("a_src_addr", ifa.src_addr, e.src);
                chk("a_oam_addr", 16'(ifa.oam_addr), 16'(e.oa));
                chk("a_oam_data", 16'(ifa.oam_data), 16'(e.dat));
                chk("a_src_rd", 16'(ifa.src_rd), 16'd1);
                chk("a_dma_active", 16'(ifa.dma_active), 16'd1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ifb.oam_write) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write", 16'(ifb.oam_addr), 16'hFFFF);
            end else begin
                e = qb.pop_front();
                chk("b_src_addr", ifb.src_addr, e.src);
                chk("b_oam_addr", 16'(ifb.oam_addr), 16'(e.oa));
                chk("b_oam_data", 16'(ifb.oam_data), 16'(e.dat));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.reg_write = 1'b0;
        ifa.reg_in    = 8'h00;
        ifb.reg_write = 1'b0;
        ifb.reg_in    = 8'h00;
        #3;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain transfer from page C1.
        wr_a(8'hC1, 0);
        @(posedge clk);
        #1;
        chk("a_active_after_delay", 16'(ifa.dma_active), 16'd1);
        chk("a_first_oam_addr", 16'(ifa.oam_addr), 16'h0000);
        repeat (159) @(posedge clk);
        #1;
        chk("a_busy_fall_161", 16'(ifa.busy), 16'd1);
        @(posedge clk);
        #1;
        chk("a_busy_fall_161", 16'(ifa.busy), 16'd0);
        chk("a_all_written", 16'(qa.size()), 16'd0);

        // Restart mid-transfer: bytes 0..49 of page 80 written, then page C0 from scratch.
        wr_a(8'h80, 0);
        repeat (50) @(posedge clk);
        #1;
        wr_a(8'hC0, 110);
        finish_a(8'hC0);

        // Asynchronous reset during byte 80.
        wr_a(8'hC3, 0);
        repeat (81) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        qa.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        wr_a(8'hD0, 0);
        finish_a(8'hD0);

        // Echo page: folded to DE only when the fold option is built in.
        wr_a(8'hFE, 0);
        finish_a(8'hFE);
        chk("a_echo_reg_out", 16'(ifa.reg_out), 16'h00FE);

        // Strobe on the final XFER cycle: byte 9F still lands, then page C2 runs.
        wr_a(8'hC4, 0);
        repeat (160) @(posedge clk);
        #1;
        chk("a_last_cycle_active", 16'(ifa.oam_addr), 16'h009F);
        wr_a(8'hC2, 0);
        finish_a(8'hC2);

        // Short instance: START_DELAY=4, LEN=8.
        ifb.reg_write = 1'b1;
        ifb.reg_in    = 8'h00;
        @(posedge clk);
        #1;
        ifb.reg_write = 1'b0;
        push(1'b1, 8'h00, 8);
        chk("b_busy_rise", 16'(ifb.busy), 16'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("b_no_write_before_T4", 16'(ifb.oam_write), 16'd0);
        @(posedge clk);
        #1;
        chk("b_first_write_T4", 16'(ifb.oam_write), 16'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("b_busy_T11", 16'(ifb.busy), 16'd1);
        @(posedge clk);
        #1;
        chk("b_busy_fall_T12", 16'(ifb.busy), 16'd0);
        chk("b_all_written", 16'(qb.size()), 16'd0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
